fifo_ctrlread_req_mc: RTL and testbench

Multi-channel successor of the single control-read request FIFO. It holds `CHANNELS` independent request queues of arbitrary (non-power-of-two) depth and merges them onto one registered valid/ready output through a round-robin arbiter. It also provides per-channel occupancy, almost-full, flush and overflow reporting. It sits between the per-engine control-read request generators and the shared memory read port.

---
 rtl/fifo_ctrlread_req_mc_if.sv | 32 +++
 rtl/fifo_ctrlread_req_mc.sv | 159 +++++++++++++++
 tb/tb_fifo_ctrlread_req_mc.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrlread_req_mc_if.sv
// Request-side and output-side signal bundle for fifo_ctrlread_req_mc.
// The master drives pushes, flushes and output ready; the slave is the FIFO.
interface fifo_ctrlread_req_mc_if #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 41,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]       wr_en;
  logic [CHANNELS*WIDTH-1:0] din;
  logic [CHANNELS-1:0]       flush;
  logic [CHANNELS-1:0]       full;
  logic [CHANNELS-1:0]       afull;
  logic [CHANNELS*CW-1:0]    count;
  logic [CHANNELS-1:0]       err_ovf;
  logic [WIDTH-1:0]          dout;
  logic [CHW-1:0]            dout_ch;
  logic                      dout_valid;
  logic                      dout_ready;

  modport master (
    output wr_en, din, flush, dout_ready,
    input  full, afull, count, err_ovf, dout, dout_ch, dout_valid
  );

  modport slave (
    input  wr_en, din, flush, dout_ready,
    output full, afull, count, err_ovf, dout, dout_ch, dout_valid
  );
endinterface

// File: rtl/fifo_ctrlread_req_mc.sv
// Multi-channel control-read request FIFO: CHANNELS independent circular
// queues of arbitrary depth, merged round-robin into one registered
// valid/ready output stage, with per-channel occupancy/flush/overflow status.
module fifo_ctrlread_req_mc #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned DEPTH        = 41,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
  input logic                    clk,
  input logic                    rst_n,
  fifo_ctrlread_req_mc_if.slave  bus
);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PW  = $clog2(DEPTH);

  logic [WIDTH-1:0]    mem_q [CHANNELS][DEPTH];

  logic [PW-1:0]       rd_ptr_q [CHANNELS];
  logic [PW-1:0]       rd_ptr_d [CHANNELS];
  logic [PW-1:0]       wr_ptr_q [CHANNELS];
  logic [PW-1:0]       wr_ptr_d [CHANNELS];
  logic [CW-1:0]       cnt_q    [CHANNELS];
  logic [CW-1:0]       cnt_d    [CHANNELS];
  logic [CHANNELS-1:0] full_q, full_d;
  logic [CHANNELS-1:0] afull_q, afull_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  logic [WIDTH-1:0]    dout_q, dout_d;
  logic [CHW-1:0]      ch_q, ch_d;
  logic                valid_q, valid_d;
  logic [CHW-1:0]      last_q, last_d;

  logic [CHANNELS-1:0] eligible;
  logic [CHANNELS-1:0] push_ok;
  logic [CHANNELS-1:0] pop;
  logic                load;
  logic                found;
  logic [CHW-1:0]      grant;
  logic [CHW-1:0]      cand;
  logic [CHANNELS*CW-1:0] count_flat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Round-robin pick of a non-empty, non-flushed channel, starting after the last grant.
  always_comb begin
    load  = !valid_q || bus.dout_ready;
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      eligible[i] = (cnt_q[i] != '0) && !bus.flush[i];
    end
    for (int unsigned off = 1; off <= CHANNELS; off++) begin
      cand = CHW'((32'(last_q) + off) % CHANNELS);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Per-channel pointer/count/status next state.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      push_ok[i]  = bus.wr_en[i] && !full_q[i] && !bus.flush[i];
      pop[i]      = load && found && (grant == CHW'(i));
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      ovf_d[i]    = ovf_q[i] | (bus.wr_en[i] & full_q[i] & ~bus.flush[i]);
      if (bus.flush[i]) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        if (push_ok[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
        if (pop[i])     rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
        if (push_ok[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CW'(1);
        else if (!push_ok[i] && pop[i]) cnt_d[i] = cnt_q[i] - CW'(1);
      end
      full_d[i]  = (cnt_d[i] == CW'(DEPTH));
      afull_d[i] = (cnt_d[i] >= CW'(AFULL_THRESH));
    end
  end

  // Output register loads when empty or being consumed this cycle.
  always_comb begin
    valid_d = valid_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (load) begin
      valid_d = found;
      if (found) begin
        dout_d = mem_q[grant][rd_ptr_q[grant]];
        ch_d   = grant;
        last_d = grant;
      end
    end
  end

  // Queue storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= bus.din[i*WIDTH +: WIDTH];
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      full_q  <= '0;
      afull_q <= '0;
      ovf_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= CHW'(CHANNELS - 1);
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Flatten per-channel counts onto the bus.
  always_comb begin
    count_flat = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      count_flat[i*CW +: CW] = cnt_q[i];
    end
  end

  assign bus.full       = full_q;
  assign bus.afull      = afull_q;
  assign bus.err_ovf    = ovf_q;
  assign bus.count      = count_flat;
  assign bus.dout       = dout_q;
  assign bus.dout_ch    = ch_q;
  assign bus.dout_valid = valid_q;
endmodule

// File: tb/tb_fifo_ctrlread_req_mc.sv
// Self-checking bench for fifo_ctrlread_req_mc: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_fifo_ctrlread_req_mc;
  localparam int W  = 64;
  localparam int D  = 41;
  localparam int CH = 4;
  localparam int AF = D - 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrlread_req_mc_if #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH)) bus ();

  fifo_ctrlread_req_mc #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH), .AFULL_THRESH(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [W-1:0] mq [CH][$];
  bit           m_valid;
  logic [W-1:0] m_dout;
  int           m_ch;
  int           m_last;
  bit [CH-1:0]  m_ovf;

  // Items actually handed over by the DUT
  logic [W-1:0] log_d [$];
  int           log_c [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cnt(input int c);
    return int'(bus.count[c*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_valid = 1'b0;
    m_dout  = '0;
    m_ch    = 0;
    m_last  = CH - 1;
    m_ovf   = '0;
  endtask

  // One clock edge of the behavioural model, from the inputs seen at that edge.
  task automatic model_edge();
    int sz [CH];
    bit load;
    int g;
    logic [W-1:0] item;
    item = '0;
    for (int c = 0; c < CH; c++) sz[c] = mq[c].size();
    load = !m_valid || bus.dout_ready;
    g = -1;
    if (load) begin
      for (int k = 1; k <= CH; k++) begin
        int c;
        c = (m_last + k) % CH;
        if (g < 0 && sz[c] > 0 && !bus.flush[c]) g = c;
      end
    end
    if (g >= 0) item = mq[g].pop_front();
    for (int c = 0; c < CH; c++) begin
      if (bus.flush[c]) mq[c].delete();
      else if (bus.wr_en[c]) begin
        if (sz[c] == D) m_ovf[c] = 1'b1;
        else mq[c].push_back(bus.din[c*W +: W]);
      end
    end
    if (load) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_dout  = item;
        m_ch    = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  logic [CH*CW-1:0] e_cnt;
  logic [CH-1:0]    e_full, e_afull;
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int c = 0; c < CH; c++) begin
        e_cnt[c*CW +: CW] = CW'(mq[c].size());
        e_full[c]  = (mq[c].size() == D);
        e_afull[c] = (mq[c].size() >= AF);
      end
      chk("valid", 64'(bus.dout_valid), 64'(m_valid));
      chk("dout", bus.dout, m_dout);
      chk("dout_ch", 64'(bus.dout_ch), 64'(m_ch));
      chk("count", 64'(bus.count), 64'(e_cnt));
      chk("full", 64'(bus.full), 64'(e_full));
      chk("afull", 64'(bus.afull), 64'(e_afull));
      chk("err_ovf", 64'(bus.err_ovf), 64'(m_ovf));
    end
  end

  task automatic step();
    if (bus.dout_valid && bus.dout_ready) begin
      log_d.push_back(bus.dout);
      log_c.push_back(int'(bus.dout_ch));
    end
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  // Channel c gets data d | (c << 8).
  task automatic drive(input logic [CH-1:0] wr, input logic [CH-1:0] fl, input logic rdy,
                       input logic [W-1:0] d);
    bus.wr_en = wr;
    bus.flush = fl;
    bus.dout_ready = rdy;
    for (int c = 0; c < CH; c++) bus.din[c*W +: W] = d | (W'(c) << 8);
  endtask

  task automatic apply_reset();
    drive('0, '0, 1'b0, '0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_d.delete();
    log_c.delete();
  endtask

  int sent [CH];
  int nxt  [CH];
  int total;

  initial begin
    drive('0, '0, 1'b0, '0);
    apply_reset();
    chk_en = 1'b1;

    // Reset state
    chk("rst_valid", 64'(bus.dout_valid), 0);
    chk("rst_count", 64'(bus.count), 0);
    chk("rst_full", 64'(bus.full), 0);
    chk("rst_dout", bus.dout, 0);

    // Single-channel fill, overflow, drain
    for (int n = 0; n < 42; n++) begin
      drive(4'b0001, '0, 1'b0, W'(n));
      step();
      if (n == 0) begin
        chk("lat_count1", 64'(cnt(0)), 1);
        chk("lat_valid0", 64'(bus.dout_valid), 0);
      end
      if (n == 1) begin
        chk("lat_valid1", 64'(bus.dout_valid), 1);
        chk("lat_dout0", bus.dout, 0);
      end
      if (n == 36) chk("afull_at36", 64'(bus.afull[0]), 0);
      if (n == 37) chk("afull_at37", 64'(bus.afull[0]), 1);
      if (n == 40) chk("full_at40", 64'(bus.full[0]), 0);
    end
    chk("fill_count", 64'(cnt(0)), 41);
    chk("fill_full", 64'(bus.full[0]), 1);
    drive(4'b0001, '0, 1'b0, 64'd99);
    step();
    chk("ovf_set", 64'(bus.err_ovf[0]), 1);
    chk("ovf_count", 64'(cnt(0)), 41);
    drive('0, '0, 1'b1, '0);
    repeat (45) step();
    chk("drain_len", 64'(log_d.size()), 42);
    for (int k = 0; k < log_d.size(); k++) chk("drain_data", log_d[k], 64'(k));
    chk("ovf_sticky", 64'(bus.err_ovf[0]), 1);

    // Round-robin fairness
    apply_reset();
    chk("rst_ovf_clear", 64'(bus.err_ovf), 0);
    for (int r = 0; r < 3; r++) begin
      drive(4'hF, '0, 1'b0, W'(r));
      step();
    end
    drive('0, '0, 1'b1, '0);
    repeat (16) step();
    chk("rr_len", 64'(log_c.size()), 12);
    for (int k = 0; k < log_c.size(); k++) chk("rr_ch", 64'(log_c[k]), 64'(k % 4));

    // Wrap-around on channel 1 with simultaneous push/pop
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(4'b0010, '0, 1'b0, W'(k));
      step();
    end
    for (int k = 5; k < 105; k++) begin
      drive(4'b0010, '0, 1'b1, W'(k));
      step();
      chk("wrap_count", 64'(cnt(1)), 4);
    end
    drive('0, '0, 1'b1, '0);
    repeat (8) step();
    chk("wrap_len", 64'(log_d.size()), 105);
    for (int k = 0; k < log_d.size(); k++) chk("wrap_data", log_d[k], 64'(k) | 64'h100);
    chk("wrap_no_ovf", 64'(bus.err_ovf), 0);

    // Flush with concurrent push on channel 2
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4'b0100, '0, 1'b0, W'(k));
      step();
    end
    chk("pre_flush_count", 64'(cnt(2)), 5);
    drive(4'b0100, 4'b0100, 1'b0, 64'd77);
    step();
    chk("flush_count", 64'(cnt(2)), 0);
    chk("flush_keep_valid", 64'(bus.dout_valid), 1);
    drive('0, '0, 1'b1, '0);
    repeat (6) step();
    chk("flush_len", 64'(log_d.size()), 1);
    if (log_d.size() > 0) chk("flush_item", log_d[0], 64'h200);
    chk("flush_idle", 64'(bus.dout_valid), 0);

    // Random backpressure with sparse multi-channel pushes
    apply_reset();
    for (int c = 0; c < CH; c++) begin sent[c] = 0; nxt[c] = 0; end
    for (int t = 0; t < 200; t++) begin
      bus.flush = '0;
      for (int c = 0; c < CH; c++) begin
        bus.wr_en[c] = ($urandom_range(0, 7) == 0);
        bus.din[c*W +: W] = W'(sent[c]) | (W'(c) << 8);
        if (bus.wr_en[c]) sent[c]++;
      end
      bus.dout_ready = 1'($urandom_range(0, 1));
      step();
    end
    drive('0, '0, 1'b1, '0);
    repeat (150) step();
    total = 0;
    for (int c = 0; c < CH; c++) total += sent[c];
    chk("bp_total", 64'(log_d.size()), 64'(total));
    chk("bp_no_ovf", 64'(bus.err_ovf), 0);
    for (int k = 0; k < log_d.size(); k++) begin
      chk("bp_order", log_d[k], W'(nxt[log_c[k]]) | (W'(log_c[k]) << 8));
      nxt[log_c[k]]++;
    end

    // Reset asserted mid-operation
    for (int k = 0; k < 3; k++) begin
      drive(4'b1011, '0, 1'b0, W'(k));
      step();
    end
    chk("pre_rst_valid", 64'(bus.dout_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.dout_valid), 0);
    chk("midrst_dout", bus.dout, 0);
    chk("midrst_ch", 64'(bus.dout_ch), 0);
    chk("midrst_count", 64'(bus.count), 0);
    chk("midrst_full", 64'(bus.full), 0);
    model_reset();
    drive('0, '0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1001, '0, 1'b0, 64'd5);
    step();
    drive('0, '0, 1'b0, '0);
    step();
    chk("post_rst_valid", 64'(bus.dout_valid), 1);
    chk("post_rst_ch0", 64'(bus.dout_ch), 0);
    drive('0, '0, 1'b1, '0);
    step();
    chk("post_rst_ch3", 64'(bus.dout_ch), 3);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
